// File: rtl/mpu_mul_ctrl.sv
// -----------------------------------------------------------------------------
// mpu_mul_ctrl
//
// Sequencer for the 5x5 signed int8 matrix multiplier. Operand A and then
// operand B are loaded one row per beat from a valid/ready input stream. One
// compute cycle captures all 25 int16 products. The result rows are then
// returned one row per beat on a valid/ready output stream.
//
// Ports
//   clk        single clock, everything on the rising edge
//   rst        synchronous, active-high reset
//   start      begin an operation (only looked at while idle)
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse after the last result row is accepted
//   in_data    one operand row, column c at [8c+7:8c], signed
//   in_valid   in_data valid
//   in_ready   controller accepts in_data this cycle
//   out_data   one result row, column c at [16c+15:16c], signed
//   out_valid  out_data valid
//   out_ready  consumer accepts out_data this cycle
//   out_row    row index (0..4) of the current out_data
//
// The datapath is fixed at ROWS=5 / IN_W=8 / OUT_W=16. The parameters only name
// those widths; the block is not meant to be re-sized.
// -----------------------------------------------------------------------------

// Combinational datapath. Each output element is sum_k A[r][k]*B[k][c]. All
// arithmetic is done at OUT_W bits, so the result wraps in two's complement.
module mpu_mul_dp #(
    parameter int ROWS  = 5,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic [ROWS*ROWS*IN_W-1:0]  i_a,
    input  logic [ROWS*ROWS*IN_W-1:0]  i_b,
    output logic [ROWS*ROWS*OUT_W-1:0] o_p
);

    // Signed dot products for every (row, column) pair
    always_comb begin
        logic signed [OUT_W-1:0] w_acc;
        logic signed [OUT_W-1:0] w_ea;
        logic signed [OUT_W-1:0] w_eb;
        o_p   = '0;
        w_acc = '0;
        w_ea  = '0;
        w_eb  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < ROWS; c++) begin
                w_acc = '0;
                for (int k = 0; k < ROWS; k++) begin
                    // Sign-extend the int8 elements before multiplying
                    w_ea  = OUT_W'($signed(i_a[(r*ROWS+k)*IN_W +: IN_W]));
                    w_eb  = OUT_W'($signed(i_b[(k*ROWS+c)*IN_W +: IN_W]));
                    w_acc = w_acc + w_ea * w_eb;
                end
                o_p[(r*ROWS+c)*OUT_W +: OUT_W] = w_acc;
            end
        end
    end

endmodule

module mpu_mul_ctrl #(
    parameter int ROWS  = 5,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [ROWS*IN_W-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ROWS*OUT_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_row
);

    localparam int          ROW_IN_W  = ROWS * IN_W;
    localparam int          ROW_OUT_W = ROWS * OUT_W;
    localparam logic [2:0]  LAST_ROW  = 3'(ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_STREAM  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic [2:0] r_row;
    logic [2:0] w_row_nxt;

    logic [ROWS*ROW_IN_W-1:0]  r_a;
    logic [ROWS*ROW_IN_W-1:0]  r_b;
    logic [ROWS*ROW_OUT_W-1:0] r_res;
    logic [ROWS*ROW_OUT_W-1:0] w_prod;

    logic                 r_busy;
    logic                 r_done;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [ROW_OUT_W-1:0] r_out_data;
    logic [2:0]           r_out_row;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_last_out;

    // Handshake decode; the ready/valid flags are registered copies of the state
    always_comb begin
        w_in_xfer  = r_in_ready && in_valid;
        w_out_xfer = r_out_valid && out_ready;
        w_last_out = (r_state == ST_STREAM) && w_out_xfer && (r_row == LAST_ROW);
    end

    mpu_mul_dp #(
        .ROWS  (ROWS),
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_dp (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    // State and row-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_row   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Next-state and next-row logic; anything without a transfer holds in place
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD_A;
                    w_row_nxt   = 3'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD_A: begin
                if (w_in_xfer) begin
                    if (r_row == LAST_ROW) begin
                        w_state_nxt = ST_LOAD_B;
                        w_row_nxt   = 3'd0;
                    end else begin
                        w_row_nxt = r_row + 3'd1;
                    end
                end else begin
                    w_state_nxt = ST_LOAD_A;
                end
            end
            ST_LOAD_B: begin
                if (w_in_xfer) begin
                    if (r_row == LAST_ROW) begin
                        w_state_nxt = ST_COMPUTE;
                        w_row_nxt   = 3'd0;
                    end else begin
                        w_row_nxt = r_row + 3'd1;
                    end
                end else begin
                    w_state_nxt = ST_LOAD_B;
                end
            end
            ST_COMPUTE: begin
                w_state_nxt = ST_STREAM;
                w_row_nxt   = 3'd0;
            end
            ST_STREAM: begin
                if (w_out_xfer) begin
                    if (r_row == LAST_ROW) begin
                        w_state_nxt = ST_IDLE;
                        w_row_nxt   = 3'd0;
                    end else begin
                        w_row_nxt = r_row + 3'd1;
                    end
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_row_nxt   = 3'd0;
            end
        endcase
    end

    // Operand capture: each accepted beat writes the row addressed by r_row
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_in_xfer && (r_state == ST_LOAD_A)) begin
            r_a[int'(r_row)*ROW_IN_W +: ROW_IN_W] <= in_data;
        end else if (w_in_xfer && (r_state == ST_LOAD_B)) begin
            r_b[int'(r_row)*ROW_IN_W +: ROW_IN_W] <= in_data;
        end
    end

    // Result buffer: snapshot of the whole product matrix in the compute cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
        end else if (r_state == ST_COMPUTE) begin
            r_res <= w_prod;
        end
    end

    // Registered outputs, driven from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= 3'd0;
        end else begin
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_last_out;
            r_in_ready  <= (w_state_nxt == ST_LOAD_A) || (w_state_nxt == ST_LOAD_B);
            r_out_valid <= (w_state_nxt == ST_STREAM);
            if (w_state_nxt == ST_STREAM) begin
                r_out_row <= w_row_nxt;
                // Row 0 comes straight from the datapath because r_res is
                // only written on the same edge. During a stall w_row_nxt
                // equals r_row, so the reload keeps the same value.
                if (r_state == ST_COMPUTE) begin
                    r_out_data <= w_prod[ROW_OUT_W-1:0];
                end else begin
                    r_out_data <= r_res[int'(w_row_nxt)*ROW_OUT_W +: ROW_OUT_W];
                end
            end else begin
                r_out_row <= 3'd0;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_row   = r_out_row;

endmodule

// File: tb/tb_mpu_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mpu_mul_ctrl
//
// Self-checking bench for mpu_mul_ctrl. The expected products come from plain
// integer matrix arithmetic that is truncated to 16 bits. Inputs are driven and
// outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mpu_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [39:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [79:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_row;

    int n_checks = 0;
    int n_fail   = 0;
    int ma[5][5];
    int mb[5][5];

    always #5 clk = ~clk;

    mpu_mul_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] row_a(input int r);
        logic [39:0] v;
        for (int c = 0; c < 5; c++) v[c*8 +: 8] = 8'(ma[r][c]);
        return v;
    endfunction

    function automatic logic [39:0] row_b(input int r);
        logic [39:0] v;
        for (int c = 0; c < 5; c++) v[c*8 +: 8] = 8'(mb[r][c]);
        return v;
    endfunction

    // Reference: full-precision integer dot product, then wrapped to 16 bits
    function automatic logic [79:0] exp_row(input int r);
        logic [79:0] v;
        int s;
        for (int c = 0; c < 5; c++) begin
            s = 0;
            for (int k = 0; k < 5; k++) s += ma[r][k] * mb[k][c];
            v[c*16 +: 16] = 16'(s);
        end
        return v;
    endfunction

    function automatic logic [39:0] junk();
        return 40'({$urandom(), $urandom()});
    endfunction

    task automatic set_ident_a();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) ma[r][c] = r*5 + c + 1;
    endtask

    task automatic set_eye_b(input int k);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) mb[r][c] = (r == c) ? k : 0;
    endtask

    task automatic set_const(input int a, input int b);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                ma[r][c] = a;
                mb[r][c] = b;
            end
    endtask

    task automatic set_random();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                ma[r][c] = int'($urandom_range(0, 255)) - 128;
                mb[r][c] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    // One full operation from IDLE.
    // in_mode:  0 = in_valid always, 1 = every other cycle, 2 = random.
    // out_mode: 0 = out_ready always, 1 = one cycle in three, 2 = random.
    task automatic do_op(input string name, input int in_mode, input int out_mode, input bit poke);
        int cyc;
        int beats;
        int guard;
        int first_valid;
        int rows;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        check({name, "_busy_start"}, busy, 1);

        beats = 0;
        guard = 0;
        while (beats < 10 && guard < 400) begin
            case (in_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 1);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (in_valid) in_data = (beats < 5) ? row_a(beats) : row_b(beats - 5);
            else          in_data = junk();
            start = poke && (beats >= 5);
            if (in_valid && in_ready) beats++;
            tick();
            cyc++;
            guard++;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = junk();
        check({name, "_beats"}, beats, 10);
        check({name, "_ready_off"}, in_ready, 0);

        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            cyc++;
            guard++;
        end
        in_valid    = 1'b0;
        first_valid = cyc;
        if (in_mode == 0) check({name, "_latency"}, first_valid, 12);

        rows  = 0;
        guard = 0;
        while (rows < 5 && guard < 200) begin
            case (out_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = poke && (rows == 2);
            check({name, "_ovalid"}, out_valid, 1);
            check({name, "_row"}, out_row, rows);
            check({name, "_data"}, out_data, exp_row(rows));
            check({name, "_done_early"}, done, 0);
            if (out_valid && out_ready) rows++;
            tick();
            cyc++;
            guard++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        check({name, "_rows"}, rows, 5);
        check({name, "_done"}, done, 1);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_ovalid_end"}, out_valid, 0);
        if (out_mode == 0) check({name, "_done_cyc"}, cyc, first_valid + 5);
        tick();
        check({name, "_done_once"}, done, 0);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_ready"}, in_ready, 0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_in_ready"}, in_ready, 0);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_out_data"}, out_data, 0);
        check({name, "_out_row"}, out_row, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 40'd0;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;

        // in_valid while idle must not be accepted
        in_valid = 1'b1;
        in_data  = junk();
        tick();
        tick();
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        in_valid = 1'b0;

        set_ident_a();
        set_eye_b(1);
        do_op("ident", 0, 0, 1'b0);

        set_const(-128, -128);
        do_op("wrap_pos", 0, 0, 1'b0);

        set_const(127, -128);
        do_op("wrap_neg", 0, 0, 1'b0);

        set_ident_a();
        set_eye_b(1);
        do_op("backpress", 0, 1, 1'b0);

        set_random();
        do_op("in_gaps", 1, 0, 1'b0);

        set_random();
        do_op("poke", 0, 0, 1'b1);
        set_random();
        do_op("after_poke", 0, 0, 1'b0);

        // Abort a load after three A rows
        set_random();
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = row_a(i);
            tick();
        end
        rst     = 1'b1;
        in_data = junk();
        tick();
        check_reset_vals("mid_rst");
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("mid_rst_idle", busy, 0);

        set_eye_b(1);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) ma[r][c] = (r == c) ? 1 : 0;
        set_eye_b(2);
        do_op("post_rst", 0, 0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            set_random();
            do_op("rand", 2, 2, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
